// File: rtl/clk_div_bank.sv
// clk_div_bank: lock-qualified reset sequencer plus NUM_CH runtime-programmable square-wave dividers.
// Dividers advance only once the wizard lock has held for 2**LOCK_W-1 cycles.
//
// state     | meaning
// WAIT_LOCK | wizard not locked; dividers held clear, rst_seq high
// STABLE    | locked; counting lock hold time, dividers still clear
// RUN       | dividers advance, rst_seq released one cycle after entry
module clk_div_bank #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 10,
  parameter int DEF_HP = 4,
  parameter int LOCK_W = 16
) (
  input  logic                    sys_clk,
  input  logic                    rst_glb,
  input  logic                    locked,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       clk_div_out,
  output logic [NUM_CH-1:0]       clk_div_pls,
  output logic                    rst_seq,
  output logic [1:0]              seq_state
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  // Last STABLE cycle is the one holding 2**LOCK_W-2, so STABLE lasts 2**LOCK_W-1 cycles.
  localparam logic [LOCK_W-1:0] LOCK_LAST = {{(LOCK_W-1){1'b1}}, 1'b0};
  localparam logic [DIV_W-1:0]  HP_RST    = DIV_W'(DEF_HP);

  seq_state_t        state;
  logic [LOCK_W-1:0] lock_cnt;
  logic              run_ok;

  assign run_ok    = (state == RUN) && locked;
  assign seq_state = state;

  always_ff @(posedge sys_clk) begin
    if (rst_glb) begin
      state    <= WAIT_LOCK;
      lock_cnt <= '0;
      rst_seq  <= 1'b1;
    end else begin
      rst_seq <= (state != RUN);
      case (state)
        WAIT_LOCK: begin
          lock_cnt <= '0;
          if (locked) state <= STABLE;
        end
        STABLE: begin
          if (!locked) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
            if (lock_cnt == LOCK_LAST) state <= RUN;
          end
        end
        RUN: begin
          if (!locked) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
          end
        end
        default: begin
          state    <= WAIT_LOCK;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] shadow_hp;
    logic [DIV_W-1:0] hp;
    logic [DIV_W-1:0] cnt;
    logic             pend;
    logic             run;
    logic             out_q;
    logic             pls_q;
    logic             tc;
    logic             apply;

    assign tc    = run && (cnt == hp);
    // A pending half-period lands only on a phase boundary, so the running phase never changes length.
    assign apply = pend && (!run_ok || !run || tc);

    assign clk_div_out[i] = out_q;
    assign clk_div_pls[i] = pls_q;

    always_ff @(posedge sys_clk) begin
      if (rst_glb) begin
        shadow_hp <= HP_RST;
        hp        <= HP_RST;
        pend      <= 1'b0;
        cnt       <= '0;
        run       <= 1'b0;
        out_q     <= 1'b0;
        pls_q     <= 1'b0;
      end else begin
        if (apply) hp <= shadow_hp;
        if (cfg_load) begin
          shadow_hp <= div_cfg[i*DIV_W +: DIV_W];
          pend      <= 1'b1;
        end else if (apply) begin
          pend <= 1'b0;
        end

        pls_q <= 1'b0;
        if (!run_ok) begin
          cnt   <= '0;
          run   <= 1'b0;
          out_q <= 1'b0;
        end else if (!run) begin
          cnt   <= '0;
          out_q <= 1'b0;
          run   <= ch_en[i];
        end else if (cnt == hp) begin
          cnt <= '0;
          // Stop only at the end of a low phase so a disable never leaves a runt high pulse.
          if (!ch_en[i] && !out_q) begin
            run <= 1'b0;
          end else begin
            out_q <= ~out_q;
            pls_q <= ~out_q;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: sequencer timing, divider waveforms, glitch-free reload,
// runt-free stop, lock loss and reset priority over cfg_load.
module tb_clk_div_bank;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 10;
  localparam int LOCK_W = 4;

  logic                    sys_clk = 1'b0;
  logic                    rst_glb;
  logic                    locked;
  logic [NUM_CH*DIV_W-1:0] div_cfg;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       clk_div_out;
  logic [NUM_CH-1:0]       clk_div_pls;
  logic                    rst_seq;
  logic [1:0]              seq_state;

  int vec  = 0;
  int miss = 0;

  clk_div_bank #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W),
    .DEF_HP(4),
    .LOCK_W(LOCK_W)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_glb    (rst_glb),
    .locked     (locked),
    .div_cfg    (div_cfg),
    .cfg_load   (cfg_load),
    .ch_en      (ch_en),
    .clk_div_out(clk_div_out),
    .clk_div_pls(clk_div_pls),
    .rst_seq    (rst_seq),
    .seq_state  (seq_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, output int n);
    n = 0;
    while (seq_state !== s && n < 40) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [NUM_CH*DIV_W-1:0] pack_cfg(input int h0, input int h1,
                                                        input int h2, input int h3);
    pack_cfg = {DIV_W'(h3), DIV_W'(h2), DIV_W'(h1), DIV_W'(h0)};
  endfunction

  initial begin
    logic [39:0] cap_a;
    logic [39:0] cap_b;
    logic [39:0] cap_c;
    logic [39:0] cap_d;
    logic [39:0] cap_e;
    int n;

    rst_glb  = 1'b1;
    locked   = 1'b1;
    cfg_load = 1'b0;
    ch_en    = '0;
    div_cfg  = pack_cfg(4, 4, 4, 4);

    // 1: reset, then lock qualification and rst_seq release
    tick();
    check("rst_state",   64'(seq_state),   64'd0);
    check("rst_rst_seq", 64'(rst_seq),     64'd1);
    check("rst_out",     64'(clk_div_out), 64'd0);
    check("rst_pls",     64'(clk_div_pls), 64'd0);
    rst_glb = 1'b0;
    tick();
    wait_state(2'd2, n);
    check("stable_len", 64'(n), 64'd15);
    check("rst_seq_at_run_entry", 64'(rst_seq), 64'd1);
    tick();
    check("rst_seq_released", 64'(rst_seq), 64'd0);

    // 2: ch0 hp=4, ch1 hp=0, ch2 hp=4 phase-aligned with ch0
    div_cfg  = pack_cfg(4, 0, 4, 4);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tick();
    ch_en = 4'b0111;
    tick();
    cap_a = '0; cap_b = '0; cap_c = '0; cap_d = '0; cap_e = '0;
    for (int k = 0; k < 24; k++) begin
      tick();
      cap_a[k] = clk_div_out[0];
      cap_b[k] = clk_div_pls[0];
      cap_c[k] = clk_div_out[1];
      cap_d[k] = clk_div_pls[1];
      cap_e[k] = clk_div_out[2];
    end
    check("div10_out0", 64'(cap_a), 64'h07C1F0);
    check("div10_pls0", 64'(cap_b), 64'h004010);
    check("div2_out1",  64'(cap_c), 64'h555555);
    check("div2_pls1",  64'(cap_d), 64'h555555);
    check("aligned_out2", 64'(cap_e), 64'h07C1F0);

    // 3: reload ch0 to 9 two cycles into a high phase
    cap_a = '0; cap_e = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      cap_a[k] = clk_div_out[0];
      cap_e[k] = clk_div_out[2];
      if (k == 2) begin
        div_cfg  = pack_cfg(9, 0, 4, 4);
        cfg_load = 1'b1;
      end
      if (k == 3) cfg_load = 1'b0;
    end
    check("reload_out0",   64'(cap_a), 64'h01FF801F);
    check("reload_keep2",  64'(cap_e), 64'h01F07C1F);

    // 4: disable ch0 two cycles into a high phase, then re-enable from idle
    cap_a = '0; cap_b = '0;
    for (int k = 0; k < 40; k++) begin
      tick();
      cap_a[k] = clk_div_out[0];
      cap_b[k] = clk_div_pls[0];
      if (k == 7) ch_en = 4'b0110;
    end
    check("stop_out0", 64'(cap_a), 64'h0000007FE0);
    check("stop_pls0", 64'(cap_b), 64'h0000000020);
    ch_en = 4'b0111;
    n = 0;
    while (clk_div_out[0] !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("restart_first_rise", 64'(n), 64'd11);

    // 5: lock loss in RUN, then relock
    locked = 1'b0;
    tick();
    check("unlock_state",   64'(seq_state),   64'd0);
    check("unlock_out",     64'(clk_div_out), 64'd0);
    check("unlock_pls",     64'(clk_div_pls), 64'd0);
    check("unlock_rst_seq_lag", 64'(rst_seq), 64'd0);
    tick();
    check("unlock_rst_seq", 64'(rst_seq), 64'd1);
    locked = 1'b1;
    tick();
    check("relock_stable", 64'(seq_state), 64'd1);
    wait_state(2'd2, n);
    check("relock_len", 64'(n), 64'd15);
    check("relock_out_clear", 64'(clk_div_out), 64'd0);

    // 6: reset mid-STABLE coincident with cfg_load
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    tick();
    tick();
    tick();
    div_cfg  = pack_cfg(2, 2, 2, 2);
    cfg_load = 1'b1;
    rst_glb  = 1'b1;
    tick();
    check("rst_win_state",   64'(seq_state), 64'd0);
    check("rst_win_rst_seq", 64'(rst_seq),   64'd1);
    rst_glb  = 1'b0;
    cfg_load = 1'b0;
    tick();
    wait_state(2'd2, n);
    check("rst_win_stable_len", 64'(n), 64'd15);
    n = 0;
    while (clk_div_out[0] !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("rst_win_first_rise", 64'(n), 64'd6);
    n = 0;
    while (clk_div_out[0] === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("rst_win_high_len", 64'(n), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
